// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation encodings,
// the per-step datapath function and burst-mode qualification.
package usr_pkg;

  localparam int unsigned USR_MAX_W = 64;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } usr_mode_e;

  typedef logic [USR_MAX_W-1:0] usr_word_t;

  function automatic logic is_burst_mode(input logic [2:0] mode);
    case (mode)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  // Operates on a zero-extended word; w is the live register width, and the
  // result is masked back to w bits so callers may truncate freely.
  function automatic usr_word_t usr_step(input logic [2:0]  mode,
                                         input usr_word_t   cur,
                                         input logic        serial_in,
                                         input usr_word_t   in,
                                         input int unsigned w);
    usr_word_t all_ones;
    usr_word_t msb_pos;
    usr_word_t mask;
    usr_word_t nxt;
    logic      msb;
    all_ones = '1;
    msb_pos  = usr_word_t'(1) << (w - 1);
    mask     = ~(all_ones << w);
    msb      = |(cur & msb_pos);
    case (mode)
      MODE_SHL:  nxt = (cur << 1) | usr_word_t'(serial_in);
      MODE_SHR:  nxt = (cur >> 1) | (serial_in ? msb_pos : '0);
      MODE_ROL:  nxt = (cur << 1) | usr_word_t'(msb);
      MODE_ROR:  nxt = (cur >> 1) | (cur[0] ? msb_pos : '0);
      MODE_ASR:  nxt = (cur >> 1) | (msb ? msb_pos : '0);
      MODE_LOAD: nxt = in;
      default:   nxt = cur;
    endcase
    return nxt & mask;
  endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: latches mode/count on an accepted start, issues one step
// per cycle while busy and pulses done at completion or on a rejected start.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             step_valid,
  output logic [2:0]       step_mode
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  usr_mode_e         r_mode, w_mode;
  logic              r_done, w_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_mode  <= w_mode;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_mode  = r_mode;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (is_burst_mode(mode) && (count != '0)) begin
            w_state = ST_BURST;
            w_cnt   = count;
            w_mode  = usr_mode_e'(mode);
          end else begin
            w_done = 1'b1;
          end
        end
      end
      ST_BURST: begin
        w_cnt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state = ST_IDLE;
          w_done  = 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign busy       = (r_state == ST_BURST);
  assign step_valid = (r_state == ST_BURST);
  assign step_mode  = r_mode;
  assign done       = r_done;

endmodule

// File: rtl/param_universal_shift_reg.sv
// Parametrised universal shift register with single-step operations and an
// autonomous multi-step burst engine.
module param_universal_shift_reg
  import usr_pkg::*;
#(
  parameter  int unsigned      WIDTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned      CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             ser_out_msb,
  output logic             ser_out_lsb
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_next;
  usr_word_t        w_full;
  logic             w_step_valid;
  logic [2:0]       w_step_mode;
  logic [2:0]       w_sel_mode;
  logic             w_apply;
  logic             w_busy;
  logic             w_done;

  usr_burst_ctrl #(
    .CNT_W(CNT_W)
  ) u_burst_ctrl (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .count      (count),
    .busy       (w_busy),
    .done       (w_done),
    .step_valid (w_step_valid),
    .step_mode  (w_step_mode)
  );

  // A burst step outranks everything; a start seen while idle suppresses en.
  always_comb begin
    w_apply    = w_step_valid | (~start & en);
    w_sel_mode = w_step_valid ? w_step_mode : mode;
    w_full     = usr_step(w_sel_mode, usr_word_t'(r_out), serial_in,
                          usr_word_t'(in), WIDTH);
    w_next     = w_apply ? WIDTH'(w_full) : r_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_out <= RESET_VAL;
    else       r_out <= w_next;
  end

  assign out         = r_out;
  assign busy        = w_busy;
  assign done        = w_done;
  assign ser_out_msb = r_out[WIDTH-1];
  assign ser_out_lsb = r_out[0];

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// Scoreboard bench for param_universal_shift_reg (8-bit main instance plus a
// 16-bit instance with a non-zero reset value).
module tb_param_universal_shift_reg;

  localparam logic [2:0] M_HOLD = 3'b000, M_SHL = 3'b001, M_SHR = 3'b010,
                         M_LOAD = 3'b011, M_ROL = 3'b100, M_ROR = 3'b101,
                         M_ASR  = 3'b110, M_RSVD = 3'b111;

  logic        clk = 1'b0;
  logic        reset, en, serial_in, start;
  logic [2:0]  mode;
  logic [7:0]  d_in;
  logic [3:0]  count;
  logic [15:0] d_in2;
  logic [4:0]  count2;
  logic [7:0]  q;
  logic        busy, done, msb, lsb;
  logic [15:0] q2;
  logic        busy2, done2, msb2, lsb2;

  always #5 clk = ~clk;

  param_universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .serial_in(serial_in),
    .in(d_in), .start(start), .count(count), .out(q), .busy(busy),
    .done(done), .ser_out_msb(msb), .ser_out_lsb(lsb)
  );

  param_universal_shift_reg #(.WIDTH(16), .RESET_VAL(16'h003C)) dut16 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .serial_in(serial_in),
    .in(d_in2), .start(start), .count(count2), .out(q2), .busy(busy2),
    .done(done2), .ser_out_msb(msb2), .ser_out_lsb(lsb2)
  );

  typedef struct {
    logic [2:0] m;
    logic       e;
    logic       si;
    logic [7:0] d;
    logic       st;
    logic [3:0] c;
    logic [7:0] q;
    logic       b;
    logic       dn;
  } cyc_t;

  typedef struct {
    logic [7:0] q;
    logic       b;
    logic       dn;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic cyc_t mk(input logic [2:0] m, input logic e, input logic si,
                              input logic [7:0] d, input logic st, input logic [3:0] c,
                              input logic [7:0] eq, input logic eb, input logic edn);
    cyc_t r;
    r.m = m; r.e = e; r.si = si; r.d = d; r.st = st; r.c = c;
    r.q = eq; r.b = eb; r.dn = edn;
    return r;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  // Drive one cycle of stimulus, record its expectation, advance past the edge.
  task automatic apply(input cyc_t s);
    exp_t x;
    mode = s.m; en = s.e; serial_in = s.si; d_in = s.d; d_in2 = {s.d, s.d};
    start = s.st; count = s.c; count2 = {1'b0, s.c};
    x.q = s.q; x.b = s.b; x.dn = s.dn;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b0; mode = M_HOLD; serial_in = 1'b0; d_in = '0;
    d_in2 = '0; start = 1'b0; count = '0; count2 = '0;
    #2;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_out got=%h want=00", q); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {busy, done}); end
    checks++; if (q2 !== 16'h003C) begin errors++; $display("FAIL reset_out16 got=%h want=003c", q2); end
    #10 reset = 1'b0;
  endtask

  task automatic test_single_step;
    cyc_t st[$];
    exp_t e;
    st.push_back(mk(M_LOAD, 1, 0, 8'hA5, 0, 0, 8'hA5, 0, 0));
    st.push_back(mk(M_SHL,  1, 1, 8'h00, 0, 0, 8'h4B, 0, 0));
    st.push_back(mk(M_SHR,  1, 0, 8'h00, 0, 0, 8'h25, 0, 0));
    st.push_back(mk(M_SHL,  0, 1, 8'hFF, 0, 0, 8'h25, 0, 0));
    st.push_back(mk(M_LOAD, 1, 0, 8'h81, 0, 0, 8'h81, 0, 0));
    st.push_back(mk(M_ROL,  1, 0, 8'h00, 0, 0, 8'h03, 0, 0));
    st.push_back(mk(M_LOAD, 1, 0, 8'h81, 0, 0, 8'h81, 0, 0));
    st.push_back(mk(M_ROR,  1, 0, 8'h00, 0, 0, 8'hC0, 0, 0));
    st.push_back(mk(M_LOAD, 1, 0, 8'h90, 0, 0, 8'h90, 0, 0));
    st.push_back(mk(M_ASR,  1, 0, 8'h00, 0, 0, 8'hC8, 0, 0));
    st.push_back(mk(M_ASR,  1, 0, 8'h00, 0, 0, 8'hE4, 0, 0));
    st.push_back(mk(M_SHR,  1, 1, 8'h00, 0, 0, 8'hF2, 0, 0));
    st.push_back(mk(M_RSVD, 1, 1, 8'h00, 0, 0, 8'hF2, 0, 0));
    st.push_back(mk(M_HOLD, 1, 1, 8'h33, 0, 0, 8'hF2, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      checks++; if (q !== e.q) begin errors++; $display("FAIL single[%0d] out got=%h want=%h", i, q, e.q); end
      checks++; if ({busy, done} !== {e.b, e.dn}) begin errors++; $display("FAIL single[%0d] busy/done got=%b want=%b", i, {busy, done}, {e.b, e.dn}); end
      checks++; if ({msb, lsb} !== {e.q[7], e.q[0]}) begin errors++; $display("FAIL single[%0d] ser_out got=%b want=%b", i, {msb, lsb}, {e.q[7], e.q[0]}); end
    end
  endtask

  task automatic test_burst_rol;
    cyc_t       st[$];
    exp_t       e;
    logic [7:0] v;
    st.push_back(mk(M_LOAD, 1, 0, 8'h01, 0, 0, 8'h01, 0, 0));
    st.push_back(mk(M_ROL,  0, 0, 8'h00, 1, 3, 8'h01, 1, 0));
    // Inputs churn while busy; a start held in the last busy cycle is ignored.
    st.push_back(mk(M_LOAD, 1, 1, 8'hFF, 1, 0, 8'h02, 1, 0));
    st.push_back(mk(M_SHR,  0, 1, 8'h00, 0, 9, 8'h04, 1, 0));
    st.push_back(mk(M_ROL,  1, 0, 8'hFF, 1, 7, 8'h08, 0, 1));
    st.push_back(mk(M_HOLD, 0, 0, 8'h00, 0, 0, 8'h08, 0, 0));
    // count above WIDTH: nine rotations of 08.
    v = 8'h08;
    st.push_back(mk(M_ROL, 0, 0, 8'h00, 1, 9, v, 1, 0));
    for (int k = 1; k <= 9; k++) begin
      v = rol8(v);
      st.push_back(mk(M_HOLD, 0, 0, 8'h00, 0, 0, v, k < 9, k == 9));
    end
    st.push_back(mk(M_HOLD, 0, 0, 8'h00, 0, 0, v, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      checks++; if (q !== e.q) begin errors++; $display("FAIL burst_rol[%0d] out got=%h want=%h", i, q, e.q); end
      checks++; if ({busy, done} !== {e.b, e.dn}) begin errors++; $display("FAIL burst_rol[%0d] busy/done got=%b want=%b", i, {busy, done}, {e.b, e.dn}); end
    end
  endtask

  task automatic test_invalid_start;
    cyc_t st[$];
    exp_t e;
    st.push_back(mk(M_ROL,  1, 1, 8'h00, 1, 0, 8'h10, 0, 1));
    st.push_back(mk(M_HOLD, 0, 0, 8'h00, 0, 0, 8'h10, 0, 0));
    st.push_back(mk(M_LOAD, 1, 0, 8'h55, 1, 4, 8'h10, 0, 1));
    st.push_back(mk(M_HOLD, 0, 0, 8'h00, 0, 0, 8'h10, 0, 0));
    st.push_back(mk(M_RSVD, 1, 0, 8'h00, 1, 2, 8'h10, 0, 1));
    st.push_back(mk(M_HOLD, 0, 0, 8'h00, 0, 0, 8'h10, 0, 0));
    st.push_back(mk(M_HOLD, 1, 0, 8'h00, 1, 5, 8'h10, 0, 1));
    st.push_back(mk(M_HOLD, 0, 0, 8'h00, 0, 0, 8'h10, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      checks++; if (q !== e.q) begin errors++; $display("FAIL invalid[%0d] out got=%h want=%h", i, q, e.q); end
      checks++; if ({busy, done} !== {e.b, e.dn}) begin errors++; $display("FAIL invalid[%0d] busy/done got=%b want=%b", i, {busy, done}, {e.b, e.dn}); end
    end
  endtask

  task automatic test_back_to_back;
    cyc_t       st[$];
    exp_t       e;
    logic [7:0] v;
    logic       si;
    st.push_back(mk(M_LOAD, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    st.push_back(mk(M_SHR,  0, 1, 8'h00, 1, 8, 8'h00, 1, 0));
    v = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      v = {1'b1, v[7:1]};
      st.push_back(mk(M_SHR, 0, 1, 8'h00, 1, 8, v, k < 8, k == 8));
    end
    // Start still held: re-accepted once busy has dropped.
    st.push_back(mk(M_SHR, 0, 0, 8'h00, 1, 8, v, 1, 0));
    for (int k = 1; k <= 8; k++) begin
      si = k[0];
      v  = {si, v[7:1]};
      st.push_back(mk(M_HOLD, 1, si, 8'hAA, 0, 0, v, k < 8, k == 8));
    end
    st.push_back(mk(M_HOLD, 0, 0, 8'h00, 0, 0, v, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      checks++; if (q !== e.q) begin errors++; $display("FAIL b2b[%0d] out got=%h want=%h", i, q, e.q); end
      checks++; if ({busy, done} !== {e.b, e.dn}) begin errors++; $display("FAIL b2b[%0d] busy/done got=%b want=%b", i, {busy, done}, {e.b, e.dn}); end
    end
  endtask

  task automatic test_reset_mid_burst;
    cyc_t st[$];
    exp_t e;
    st.push_back(mk(M_LOAD, 1, 0, 8'h5A, 0, 0, 8'h5A, 0, 0));
    st.push_back(mk(M_ROR,  0, 0, 8'h00, 1, 5, 8'h5A, 1, 0));
    st.push_back(mk(M_ROR,  0, 0, 8'h00, 0, 0, 8'h2D, 1, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      checks++; if (q !== e.q) begin errors++; $display("FAIL prereset[%0d] out got=%h want=%h", i, q, e.q); end
      checks++; if ({busy, done} !== {e.b, e.dn}) begin errors++; $display("FAIL prereset[%0d] busy/done got=%b want=%b", i, {busy, done}, {e.b, e.dn}); end
    end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL prereset busy16 got=%b want=1", busy2); end
    #2 reset = 1'b1;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL midreset out got=%h want=00", q); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midreset busy/done got=%b want=00", {busy, done}); end
    checks++; if (q2 !== 16'h003C) begin errors++; $display("FAIL midreset out16 got=%h want=003c", q2); end
    checks++; if ({busy2, done2} !== 2'b00) begin errors++; $display("FAIL midreset busy/done16 got=%b want=00", {busy2, done2}); end
    reset = 1'b0;
    st.delete();
    for (int k = 0; k < 6; k++) st.push_back(mk(M_HOLD, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    foreach (st[i]) begin
      apply(st[i]);
      e = sb.pop_front();
      checks++; if (q !== e.q) begin errors++; $display("FAIL postreset[%0d] out got=%h want=%h", i, q, e.q); end
      checks++; if ({busy, done} !== {e.b, e.dn}) begin errors++; $display("FAIL postreset[%0d] busy/done got=%b want=%b", i, {busy, done}, {e.b, e.dn}); end
      checks++; if ({q2, busy2, done2} !== {16'h003C, 2'b00}) begin errors++; $display("FAIL postreset16[%0d] got=%h/%b want=003c/00", i, q2, {busy2, done2}); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_step();
    test_burst_rol();
    test_invalid_start();
    test_back_to_back();
    test_reset_mid_burst();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard leftover got=%0d want=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
